// File: rtl/tristate_bus_port.sv
// Half-duplex device-end port for a shared tristate bus: drives accepted transmit words
// for one cycle, enforces a released turnaround gap, and samples the bus on request.
//
// state  | meaning
// IDLE   | bus released, ready for a transmit or a sample request
// DRIVE  | one cycle driving out_reg onto the bus
// TURN   | bus released for TURN_CYCLES cycles, requests ignored
// SAMPLE | one cycle with bus released; bus captured at the closing edge
module tristate_bus_port #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  inout  wire  [WIDTH-1:0] bus,
  output logic             bus_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    TURN   = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("tristate_bus_port: TURN_CYCLES must be in 1..15");
  end

  state_t           state, state_nxt;
  logic [3:0]       turn_cnt;
  logic [WIDTH-1:0] out_reg;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (tx_valid)    state_nxt = DRIVE;
        else if (rx_req) state_nxt = SAMPLE;
      end
      DRIVE:  state_nxt = TURN;
      TURN:   if (turn_cnt == 4'd0) state_nxt = IDLE;
      SAMPLE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bus_oe gets its own flop (decoded from next state) so the enable never glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bus_oe   <= 1'b0;
      turn_cnt <= 4'd0;
      out_reg  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus_oe   <= (state_nxt == DRIVE);
      rx_valid <= (state == SAMPLE);
      case (state)
        IDLE:   if (tx_valid) out_reg <= tx_data;
        DRIVE:  turn_cnt <= TURN_LOAD;
        TURN:   if (turn_cnt != 4'd0) turn_cnt <= turn_cnt - 4'd1;
        SAMPLE: rx_data <= bus;
        default: ;
      endcase
    end
  end

  assign tx_ready = (state == IDLE);
  assign bus      = bus_oe ? out_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_port.sv
// Scoreboard bench for tristate_bus_port: stimulus queues expected drive/sample words,
// monitors pop and compare when the DUT drives the bus or pulses rx_valid.
module tb_tristate_bus_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: TURN_CYCLES=1, with an external bus driver
  logic       rst_a, txv_a, rxr_a, ext_en_a;
  logic [7:0] txd_a, ext_val_a;
  wire        txr_a, rxv_a, oe_a;
  wire  [7:0] rxd_a;
  wire  [7:0] bus_a;
  assign bus_a = ext_en_a ? ext_val_a : 8'bz;

  // instance B: TURN_CYCLES=3, back-to-back transmits only
  logic       rst_b, txv_b, rxr_b;
  logic [7:0] txd_b;
  wire        txr_b, rxv_b, oe_b;
  wire  [7:0] rxd_b;
  wire  [7:0] bus_b;

  tristate_bus_port #(.WIDTH(8), .TURN_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst_a), .tx_valid(txv_a), .tx_data(txd_a), .tx_ready(txr_a),
    .rx_req(rxr_a), .rx_valid(rxv_a), .rx_data(rxd_a), .bus(bus_a), .bus_oe(oe_a));

  tristate_bus_port #(.WIDTH(8), .TURN_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst_b), .tx_valid(txv_b), .tx_data(txd_b), .tx_ready(txr_b),
    .rx_req(rxr_b), .rx_valid(rxv_b), .rx_data(rxd_b), .bus(bus_b), .bus_oe(oe_b));

  int errors = 0;
  int checks = 0;

  logic [7:0] q_drv_a[$];
  logic [7:0] q_rx_a[$];
  logic [7:0] q_drv_b[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected", name);
  endfunction

  // monitor A
  logic prev_oe_a = 1'b0;
  always @(negedge clk) begin
    if (!rst_a) begin
      if (oe_a) begin
        if (q_drv_a.size() == 0) flag("drv_a_unexpected");
        else chk("drv_a_data", bus_a, q_drv_a.pop_front());
        chk("drv_a_gap", prev_oe_a, 1'b0);
      end
      if (rxv_a) begin
        if (q_rx_a.size() == 0) flag("rx_a_unexpected");
        else chk("rx_a_data", rxd_a, q_rx_a.pop_front());
      end
    end
    prev_oe_a = oe_a;
  end

  // monitor B
  int   cyc_b = 0;
  int   last_drv_b = -1;
  logic prev_oe_b = 1'b0;
  always @(posedge clk) cyc_b++;
  always @(negedge clk) begin
    if (!rst_b) begin
      if (oe_b) begin
        if (q_drv_b.size() == 0) flag("drv_b_unexpected");
        else chk("drv_b_data", bus_b, q_drv_b.pop_front());
        chk("drv_b_gap", prev_oe_b, 1'b0);
        if (last_drv_b >= 0) chk("b2b_spacing", cyc_b - last_drv_b, 5);
        last_drv_b = cyc_b;
      end
      if (rxv_b) flag("rx_b_unexpected");
    end
    prev_oe_b = oe_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; txv_a = 1'b1; txd_a = 8'hA5; rxr_a = 1'b0;
    ext_en_a = 1'b1; ext_val_a = 8'hC3;
    rst_b = 1'b1; txv_b = 1'b0; txd_b = 8'h00; rxr_b = 1'b0;

    // reset held with tx_valid asserted
    repeat (2) begin
      @(negedge clk);
      chk("rst_oe", oe_a, 1'b0);
      chk("rst_bus_released", bus_a, 8'hC3);
      chk("rst_tx_ready", txr_a, 1'b1);
      chk("rst_rx_valid", rxv_a, 1'b0);
      chk("rst_rx_data", rxd_a, 8'h00);
    end
    step();
    rst_a = 1'b0; rst_b = 1'b0; txv_a = 1'b0; ext_en_a = 1'b0;
    step();
    chk("idle_ready", txr_a, 1'b1);
    chk("idle_oe", oe_a, 1'b0);

    // single transmit
    txv_a = 1'b1; txd_a = 8'h3C; q_drv_a.push_back(8'h3C);
    step();
    txv_a = 1'b0;
    chk("drive_oe", oe_a, 1'b1);
    chk("drive_not_ready", txr_a, 1'b0);
    step();
    chk("turn_oe", oe_a, 1'b0);
    chk("turn_not_ready", txr_a, 1'b0);
    ext_en_a = 1'b1; ext_val_a = 8'h66;
    #1;
    chk("turn_bus_released", bus_a, 8'h66);
    ext_en_a = 1'b0;
    step();
    chk("ready_after_turn", txr_a, 1'b1);

    // receive
    ext_en_a = 1'b1; ext_val_a = 8'h5A;
    rxr_a = 1'b1; q_rx_a.push_back(8'h5A);
    step();
    rxr_a = 1'b0;
    chk("sample_oe", oe_a, 1'b0);
    chk("sample_not_ready", txr_a, 1'b0);
    chk("sample_rx_valid", rxv_a, 1'b0);
    step();
    chk("ready_after_sample", txr_a, 1'b1);
    step();
    chk("rx_valid_one_cycle", rxv_a, 1'b0);
    chk("rx_data_hold", rxd_a, 8'h5A);
    ext_en_a = 1'b0;

    // simultaneous tx and rx: transmit wins, held rx_req samples after turn
    txv_a = 1'b1; txd_a = 8'hF0; rxr_a = 1'b1;
    q_drv_a.push_back(8'hF0); q_rx_a.push_back(8'h0F);
    step();
    txv_a = 1'b0;
    step();
    ext_en_a = 1'b1; ext_val_a = 8'h0F;
    step();
    chk("sim_idle_ready", txr_a, 1'b1);
    step();
    rxr_a = 1'b0;
    chk("sim_sample_oe", oe_a, 1'b0);
    step();
    step();
    chk("sim_rx_data", rxd_a, 8'h0F);
    ext_en_a = 1'b0;

    // async reset in the middle of a drive cycle
    txv_a = 1'b1; txd_a = 8'h77; q_drv_a.push_back(8'h77);
    step();
    txv_a = 1'b0;
    @(negedge clk);
    #2;
    rst_a = 1'b1; ext_en_a = 1'b1; ext_val_a = 8'h99;
    #1;
    chk("async_rst_oe", oe_a, 1'b0);
    chk("async_rst_bus_released", bus_a, 8'h99);
    chk("async_rst_ready", txr_a, 1'b1);
    step();
    rst_a = 1'b0; ext_en_a = 1'b0;
    step();
    chk("post_rst_ready", txr_a, 1'b1);
    chk("post_rst_oe", oe_a, 1'b0);

    // back-to-back transmits on TURN_CYCLES=3
    txv_b = 1'b1; txd_b = 8'h01;
    q_drv_b.push_back(8'h01); q_drv_b.push_back(8'h02);
    step();
    txd_b = 8'h02;
    repeat (5) @(posedge clk);
    #1;
    txv_b = 1'b0;
    repeat (6) step();

    chk("drv_a_drained", q_drv_a.size(), 0);
    chk("rx_a_drained", q_rx_a.size(), 0);
    chk("drv_b_drained", q_drv_b.size(), 0);
    chk("b_ready_end", txr_b, 1'b1);
    chk("b_rx_data_end", rxd_b, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
